md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multi-cycle multiply/divide unit owning the HI/LO register pair; sequential counterpart to the
//   single-cycle ALU. It sits in the EX stage beside the ALU and takes the same num1/num2 operands.
//   It accepts one operation per start pulse, holds busy for a fixed latency, then commits HI/LO.
//   The controller stalls any HI/LO reader or md issue while busy=1.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (legal range 1..31)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (legal range 1..31)
// PORTS
//   clk          in   1   single clock; all state changes on rising edge
//   reset        in   1   asynchronous, active-high reset
//   num1         in   32  operand A / dividend / MTHI,MTLO source
//   num2         in   32  operand B / divisor
//   md_op        in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 invalid
//   start        in   1   issue md_op this cycle (sampled on clk rise)
//   busy         out  1   operation in flight
//   done         out  1   one-cycle pulse in the cycle after HI/LO commit
//   div_by_zero  out  1   one-cycle pulse: DIV/DIVU issued with num2==0
//   op_invalid   out  1   one-cycle pulse: start with md_op 6/7
//   hi           out  32  HI register
//   lo           out  32  LO register
// BEHAVIOUR
//   Reset (async, any time, including mid-operation): state IDLE, counter 0, hi=lo=0,
//     busy=done=div_by_zero=op_invalid=0. An in-flight op is discarded.
//   FSM: IDLE, BUSY.
//     IDLE + start + MULT/MULTU: compute and latch the result into internal regs at the start edge,
//       load counter=MULT_CYCLES, go to BUSY.
//     IDLE + start + DIV/DIVU with num2!=0: same, using DIV_CYCLES.
//     IDLE + start + DIV/DIVU with num2==0: stay IDLE, hi/lo unchanged, div_by_zero=1 for 1 cycle.
//     IDLE + start + MTHI/MTLO: hi (resp. lo) <= num1 at that edge, no busy, no done.
//     IDLE + start + md_op 6/7: stay IDLE, op_invalid=1 for 1 cycle, hi/lo unchanged.
//     BUSY: counter decrements each edge. On the edge where it reaches 0: commit the pending
//       hi/lo, go to IDLE, done=1 in the following cycle.
//   Timing: start is sampled at edge k. busy=1 from edge k up to edge k+N (N = latency param),
//     so busy is high for exactly N cycles. hi/lo show new values from edge k+N.
//     A new start is accepted in the cycle busy drops (at edge k+N), i.e. back-to-back issue.
//   start while busy=1: ignored entirely (no flags, operands not sampled). The controller must hold.
//   hi/lo keep their old values throughout BUSY. They change only at commit or by MTHI/MTLO.
//   Arithmetic: MULT gives signed 32x32->64 and MULTU unsigned 32x32->64, with {hi,lo}=product.
//     DIVU: lo=num1/num2, hi=num1%num2 (unsigned).
//     DIV: quotient truncates toward zero, remainder takes the dividend's sign; lo=quot, hi=rem.
//     DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
//   Operands are captured at the start edge. Later num1/num2 changes do not affect the result.
// TESTING
//   1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy exactly 5 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulse.
//   2 MULT 0xFFFFFFFE(-2)*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles.
//   3 DIVU 100/0 -> div_by_zero pulse, busy stays 0, hi/lo unchanged. md_op=7 -> op_invalid pulse only.
//   4 MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, busy never set.
//     Second MULT with start held during busy -> ignored. Reissue on the release cycle -> accepted.
//   5 reset asserted at cycle 3 of DIV -> busy/hi/lo go to 0 immediately (async). No done pulse after release.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit that owns the HI/LO register pair.
//
// Timing model:
// - The result is computed combinationally from the operands present at the start edge.
//   It is parked in pending registers, then committed to HI/LO after a fixed latency.
// - The latency is MULT_CYCLES for multiplies and DIV_CYCLES for divides.
// - busy is high for exactly that many cycles.
// - done pulses in the cycle after the commit.
// - A start that arrives on the commit edge is accepted, so operations can issue back-to-back.
// - A start on any other busy edge is ignored.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic [2:0]  md_op,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        op_invalid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] pend_hi_reg, pend_hi_next;
    logic [31:0] pend_lo_reg, pend_lo_next;
    logic        done_reg, done_next;
    logic        dbz_reg, dbz_next;
    logic        inv_reg, inv_next;

    logic        divisor_zero;
    logic [31:0] divisor;
    logic signed [63:0] a_s;
    logic signed [63:0] b_mul_s;
    logic signed [63:0] b_div_s;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        last_cycle;
    logic        accept;

    // Operand conditioning and the arithmetic datapath.
    // A zero divisor is replaced by 1 so the dividers never see zero.
    // That result is discarded anyway.
    // Signed division is done at 64 bits, so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
    always_comb begin
        divisor_zero = (num2 == 32'd0);
        divisor      = divisor_zero ? 32'd1 : num2;
        a_s          = {{32{num1[31]}}, num1};
        b_mul_s      = {{32{num2[31]}}, num2};
        b_div_s      = {{32{divisor[31]}}, divisor};
        prod_s       = 64'(a_s * b_mul_s);
        prod_u       = {32'd0, num1} * {32'd0, num2};
        quot_s       = 32'(a_s / b_div_s);
        rem_s        = 32'(a_s % b_div_s);
        quot_u       = num1 / divisor;
        rem_u        = num1 % divisor;
    end

    // A start is taken when idle, or on the final busy edge (back-to-back issue).
    always_comb begin
        last_cycle = (state_reg == BUSY) && (count_reg == 5'd1);
        accept     = start && ((state_reg == IDLE) || last_cycle);
    end

    // Next-state logic: countdown/commit first, then any newly accepted operation.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        done_next    = 1'b0;
        dbz_next     = 1'b0;
        inv_next     = 1'b0;

        if (state_reg == BUSY) begin
            count_next = count_reg - 5'd1;
            if (last_cycle) begin
                hi_next    = pend_hi_reg;
                lo_next    = pend_lo_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
        end

        if (accept) begin
            case (md_op)
                OP_MULT: begin
                    pend_hi_next = prod_s[63:32];
                    pend_lo_next = prod_s[31:0];
                    count_next   = MULT_N;
                    state_next   = BUSY;
                end
                OP_MULTU: begin
                    pend_hi_next = prod_u[63:32];
                    pend_lo_next = prod_u[31:0];
                    count_next   = MULT_N;
                    state_next   = BUSY;
                end
                OP_DIV: begin
                    if (divisor_zero) begin
                        dbz_next = 1'b1;
                    end else begin
                        pend_hi_next = rem_s;
                        pend_lo_next = quot_s;
                        count_next   = DIV_N;
                        state_next   = BUSY;
                    end
                end
                OP_DIVU: begin
                    if (divisor_zero) begin
                        dbz_next = 1'b1;
                    end else begin
                        pend_hi_next = rem_u;
                        pend_lo_next = quot_u;
                        count_next   = DIV_N;
                        state_next   = BUSY;
                    end
                end
                OP_MTHI: hi_next  = num1;
                OP_MTLO: lo_next  = num1;
                default: inv_next = 1'b1;
            endcase
        end
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= 5'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
            inv_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            done_reg    <= done_next;
            dbz_reg     <= dbz_next;
            inv_reg     <= inv_next;
        end
    end

    // Output mapping.
    always_comb begin
        busy        = (state_reg == BUSY);
        done        = done_reg;
        div_by_zero = dbz_reg;
        op_invalid  = inv_reg;
        hi          = hi_reg;
        lo          = lo_reg;
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed and random checks of md_unit against an arithmetic reference model.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [2:0]  md_op;
    logic        start;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        op_invalid;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .num1       (num1),
        .num2       (num2),
        .md_op      (md_op),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .op_invalid (op_invalid),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results {hi, lo}, computed from the arithmetic definitions with 64-bit integers.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return 64'(ua * ub);
            3'd2: begin
                q = 64'(sa / sb);
                r = 64'(sa % sb);
                return {r[31:0], q[31:0]};
            end
            3'd3: return {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    // Issue one op, then follow it to completion against the model.
    // Operands are scrambled right after the start edge to prove they were captured at that edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int n;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        md_op = op;
        num1  = a;
        num2  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        num1  = $urandom;
        num2  = $urandom;
        if (op <= 3'd1 || ((op == 3'd2 || op == 3'd3) && b != 32'd0)) begin
            r = ref_md(op, a, b);
            n = (op <= 3'd1) ? MULT_N : DIV_N;
            for (int i = 0; i < n; i++) begin
                check("busy_hold", busy, 1);
                check("hi_hold", hi, old_hi);
                check("lo_hold", lo, old_lo);
                check("done_early", done, 0);
                tick();
            end
            check("busy_drop", busy, 0);
            check("hi_result", hi, r[63:32]);
            check("lo_result", lo, r[31:0]);
            check("done_pulse", done, 1);
            m_hi = r[63:32];
            m_lo = r[31:0];
            tick();
            check("done_clear", done, 0);
        end else if (op == 3'd2 || op == 3'd3) begin
            check("dbz_pulse", div_by_zero, 1);
            check("dbz_busy", busy, 0);
            check("dbz_hi", hi, old_hi);
            check("dbz_lo", lo, old_lo);
            tick();
            check("dbz_clear", div_by_zero, 0);
            check("dbz_nodone", done, 0);
        end else if (op == 3'd4 || op == 3'd5) begin
            if (op == 3'd4) m_hi = a;
            else m_lo = a;
            check("mt_hi", hi, m_hi);
            check("mt_lo", lo, m_lo);
            check("mt_busy", busy, 0);
            check("mt_done", done, 0);
        end else begin
            check("inv_pulse", op_invalid, 1);
            check("inv_busy", busy, 0);
            check("inv_hi", hi, old_hi);
            check("inv_lo", lo, old_lo);
            tick();
            check("inv_clear", op_invalid, 0);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        num1  = 32'd0;
        num2  = 32'd0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_flags", {done, div_by_zero, op_invalid}, 0);
        reset = 1'b0;
        tick();

        // MULTU with maximum operands, then signed MULT and DIV with negative values.
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("t1_hi", hi, 32'hFFFFFFFE);
        check("t1_lo", lo, 32'h00000001);
        run_op(3'd0, 32'hFFFFFFFE, 32'd3);
        check("t2_mult_hi", hi, 32'hFFFFFFFF);
        check("t2_mult_lo", lo, 32'hFFFFFFFA);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2);
        check("t2_div_lo", lo, 32'hFFFFFFFD);
        check("t2_div_hi", hi, 32'hFFFFFFFF);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'h00000000);
        run_op(3'd3, 32'd100, 32'd7);

        // Divide by zero, invalid op, and consecutive MTHI/MTLO.
        run_op(3'd3, 32'd100, 32'd0);
        run_op(3'd2, 32'd5, 32'd0);
        run_op(3'd7, 32'd1, 32'd2);
        run_op(3'd6, 32'd1, 32'd2);
        run_op(3'd4, 32'h1234, 32'd0);
        run_op(3'd5, 32'h5678, 32'd0);
        check("t4_hi", hi, 32'h1234);
        check("t4_lo", lo, 32'h5678);

        // Start held through busy: ignored until the final edge, where it issues back-to-back.
        md_op = 3'd0;
        num1  = 32'd7;
        num2  = 32'hFFFFFFFD;
        start = 1'b1;
        tick();
        md_op = 3'd1;
        num1  = 32'd1000;
        num2  = 32'd3;
        for (int i = 0; i < MULT_N; i++) begin
            check("b2b_busy1", busy, 1);
            check("b2b_hi_hold", hi, 32'h1234);
            tick();
        end
        start = 1'b0;
        check("b2b_busy_cont", busy, 1);
        check("b2b_done1", done, 1);
        check("b2b_hi1", hi, 32'hFFFFFFFF);
        check("b2b_lo1", lo, 32'hFFFFFFEB);
        for (int i = 0; i < MULT_N - 1; i++) begin
            tick();
            check("b2b_busy2", busy, 1);
            check("b2b_done_mid", done, 0);
        end
        tick();
        check("b2b_busy_end", busy, 0);
        check("b2b_done2", done, 1);
        check("b2b_hi2", hi, 32'd0);
        check("b2b_lo2", lo, 32'd3000);
        m_hi = 32'd0;
        m_lo = 32'd3000;
        tick();

        // Asynchronous reset in the middle of a divide.
        md_op = 3'd2;
        num1  = 32'd1000;
        num2  = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < DIV_N + 3; i++) begin
            check("arst_nodone", {busy, done}, 0);
            tick();
        end
        check("arst_hi_after", hi, 0);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op(rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
